// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared types and defaults for the core-to-controller RAM lane
// Lane pinout between one core port and the memory controller:
//   core -> controller : rden, wren, address[AW-1:0], din[DW-1:0]
//   controller -> core : acq (grant for this lane), dq[DW-1:0] (this lane's read data)
// The core holds rden/wren/address/din steady until acq, keeps them through the
// RAM access window, and drops them before issuing anything new.
package mem_if_pkg;

   localparam int MEM_AW = 8;
   localparam int MEM_DW = 8;
   // Registered address stage plus registered RAM q stage in the controller.
   localparam int MEM_HOLD_CYCLES = 2;
   localparam int MEM_TIMEOUT = 64;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      HOLD    = 2'd2,
      RELEASE = 2'd3
   } port_state_t;

   // Wait counter must hold the value TIMEOUT; keep at least one bit when disabled.
   function automatic int wait_cnt_width(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/mem_req_port_if.sv
// rtl/mem_req_port_if.sv - core request/response handshake plus controller lane signals
interface mem_req_port_if
   import mem_if_pkg::*;
#(
   parameter int AW = MEM_AW,
   parameter int DW = MEM_DW
) ();

   logic          req_valid;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          req_ready;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          rden;
   logic          wren;
   logic [AW-1:0] address;
   logic [DW-1:0] din;
   logic          acq;
   logic [DW-1:0] dq;

   // Core pipeline and memory controller side.
   modport master (
      output req_valid, req_we, req_addr, req_wdata, acq, dq,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, rden, wren, address, din
   );

   // The request port itself.
   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, acq, dq,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, rden, wren, address, din
   );

endinterface

// File: rtl/mem_req_port.sv
// rtl/mem_req_port.sv - core-side initiator holding a single RAM request until granted and completed
module mem_req_port
   import mem_if_pkg::*;
#(
   parameter int AW          = MEM_AW,
   parameter int DW          = MEM_DW,
   parameter int HOLD_CYCLES = MEM_HOLD_CYCLES,
   parameter int TIMEOUT     = MEM_TIMEOUT
) (
   input logic           clk,
   input logic           rst_n,
   mem_req_port_if.slave bus
);

   localparam int         WW       = wait_cnt_width(TIMEOUT);
   localparam logic [3:0] HOLD_TGT = 4'(HOLD_CYCLES);

   port_state_t   state, state_n;
   logic          rden_q, rden_n;
   logic          wren_q, wren_n;
   logic          rsp_valid_q, rsp_valid_n;
   logic          rsp_err_q, rsp_err_n;
   logic [AW-1:0] addr_q, addr_n;
   logic [DW-1:0] din_q, din_n;
   logic [DW-1:0] rdata_q, rdata_n;
   logic [WW-1:0] wait_q, wait_n, wait_inc;
   logic [3:0]    hold_q, hold_n, hold_inc;
   logic          timeout_hit;

   // Saturating increments; neither counter ever wraps.
   assign wait_inc    = (wait_q == '1) ? wait_q : wait_q + 1'b1;
   assign hold_inc    = (hold_q == 4'hF) ? hold_q : hold_q + 4'd1;
   assign timeout_hit = (TIMEOUT != 0) && (wait_inc == WW'(TIMEOUT));

   // Next-state and next-output decode; registers hold unless a transition changes them.
   always_comb begin
      state_n     = state;
      rden_n      = rden_q;
      wren_n      = wren_q;
      addr_n      = addr_q;
      din_n       = din_q;
      rdata_n     = rdata_q;
      rsp_valid_n = 1'b0;
      rsp_err_n   = 1'b0;
      wait_n      = wait_q;
      hold_n      = hold_q;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               addr_n  = bus.req_addr;
               din_n   = bus.req_wdata;
               rden_n  = ~bus.req_we;
               wren_n  = bus.req_we;
               wait_n  = '0;
               hold_n  = '0;
               state_n = REQ;
            end
         end
         REQ: begin
            if (bus.acq) begin
               hold_n = 4'd1;
               if (HOLD_TGT == 4'd1) begin
                  // A single-cycle window completes on the grant cycle itself.
                  if (rden_q) rdata_n = bus.dq;
                  rden_n      = 1'b0;
                  wren_n      = 1'b0;
                  rsp_valid_n = 1'b1;
                  state_n     = RELEASE;
               end else begin
                  state_n = HOLD;
               end
            end else begin
               wait_n = wait_inc;
               if (timeout_hit) begin
                  rden_n      = 1'b0;
                  wren_n      = 1'b0;
                  rsp_valid_n = 1'b1;
                  rsp_err_n   = 1'b1;
                  state_n     = RELEASE;
               end
            end
         end
         HOLD: begin
            if (!bus.acq) begin
               // Grant withdrawn before the data window closed: abort with error.
               rden_n      = 1'b0;
               wren_n      = 1'b0;
               rsp_valid_n = 1'b1;
               rsp_err_n   = 1'b1;
               state_n     = RELEASE;
            end else begin
               hold_n = hold_inc;
               if (hold_inc == HOLD_TGT) begin
                  if (rden_q) rdata_n = bus.dq;
                  rden_n      = 1'b0;
                  wren_n      = 1'b0;
                  rsp_valid_n = 1'b1;
                  state_n     = RELEASE;
               end
            end
         end
         RELEASE: begin
            rden_n = 1'b0;
            wren_n = 1'b0;
            if (!bus.acq) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // State and registered outputs; reset drops the lane request immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rden_q      <= 1'b0;
         wren_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         addr_q      <= '0;
         din_q       <= '0;
         rdata_q     <= '0;
         wait_q      <= '0;
         hold_q      <= '0;
      end else begin
         state       <= state_n;
         rden_q      <= rden_n;
         wren_q      <= wren_n;
         rsp_valid_q <= rsp_valid_n;
         rsp_err_q   <= rsp_err_n;
         addr_q      <= addr_n;
         din_q       <= din_n;
         rdata_q     <= rdata_n;
         wait_q      <= wait_n;
         hold_q      <= hold_n;
      end
   end

   assign bus.req_ready = (state == IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rdata_q;
   assign bus.rden      = rden_q;
   assign bus.wren      = wren_q;
   assign bus.address   = addr_q;
   assign bus.din       = din_q;

endmodule

// File: doc/mem_req_port.md
Name: mem_req_port

Overview:
- Core-side initiator for the shared-RAM arbitration interface. One instance per core, on the core's own rden/wren/address/din/acq/dq lane into the memory controller.
- Accepts single 8-bit read or write requests from the core pipeline over a valid/ready handshake.
- Drives and holds the controller request lines, waits for grant (acq), holds through the RAM access window, captures read data, then releases.
- Guarantees the hold-until-acq and release-before-next-request discipline the arbiter depends on.

Parameters:
- AW, 8, RAM address width per core lane.
- DW, 8, data width per core lane.
- HOLD_CYCLES, 2, number of acq-high cycles to hold the request before read data is taken (covers the registered address plus registered RAM q path); legal range 1..15.
- TIMEOUT, 64, cycles to wait for acq before abandoning the request; 0 disables the timeout.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core request strobe
- req_we  in  1  1 = write, 0 = read
- req_addr  in  AW  request address
- req_wdata  in  DW  write data
- req_ready  out  1  port idle, request accepted when req_valid & req_ready
- rsp_valid  out  1  one-cycle completion pulse, read or write
- rsp_rdata  out  DW  captured read data, stable until the next read completes
- rsp_err  out  1  one-cycle pulse, coincident with rsp_valid, on timeout or early acq drop
- rden  out  1  to controller, read request
- wren  out  1  to controller, write request
- address  out  AW  to controller
- din  out  DW  to controller
- acq  in  1  from controller, grant for this lane
- dq  in  DW  from controller, this lane's read data

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - rden, wren, rsp_valid and rsp_err = 0.
  - address, din and rsp_rdata = 0.
  - Counters cleared.
  - req_ready = 1 once rst_n deasserts.
  - A reset in mid-transaction drops rden/wren immediately. No response is issued.
- Outputs are registered, except req_ready, which is decoded as (state==IDLE).
- IDLE:
  - On accept, latch address/din and set rden=~req_we, wren=req_we in the next cycle.
  - Go to REQ. Clear the wait counter.
- REQ:
  - Hold rden/wren/address/din constant.
  - acq=1: go to HOLD, hold count = 1.
  - acq=0: increment the wait counter. If TIMEOUT != 0 and count reaches TIMEOUT, then:
    - drop rden/wren;
    - pulse rsp_valid and rsp_err;
    - go to RELEASE.
- HOLD:
  - Keep rden/wren asserted. Increment the hold count on each cycle with acq=1.
  - HOLD_CYCLES==1 is allowed: capture happens in the same cycle that enters HOLD.
  - Capture, in the cycle where acq=1 and hold count == HOLD_CYCLES:
    - for a read, rsp_rdata <= dq;
    - drop rden/wren next cycle;
    - pulse rsp_valid;
    - go to RELEASE.
  - acq=0 before capture (controller protocol violation): drop rden/wren, pulse rsp_valid and rsp_err, go to RELEASE. rsp_rdata is unchanged.
- RELEASE:
  - rden=wren=0. Wait for acq=0, then go to IDLE.
  - Covers the one-cycle lag before the controller clears acq.
  - acq already 0 on entry: go to IDLE the next cycle.
- Timing: minimum accept-to-rsp_valid latency = 2 + HOLD_CYCLES cycles, when acq rises the cycle after rden.
- Only one outstanding request. req_valid during non-IDLE states is ignored; the core must keep req_valid held until it sees req_ready.
- Write completion returns rsp_valid with rsp_err=0. rsp_rdata is not modified by writes.
- rden and wren are never both 1. They never toggle while in REQ or HOLD.
- The counters saturate and do not wrap. The wait counter is $clog2(TIMEOUT+1) bits wide, and the hold counter is 4 bits.

Decomposition:
- Shared package mem_if_pkg holds:
  - the state enum (IDLE, REQ, HOLD, RELEASE);
  - default AW/DW;
  - the HOLD_CYCLES default, which must match the controller's registered-address plus RAM-latency depth.
- The block is a single module with no sub-module; the FSM and two counters fit in one file.
- The controller-side lane pinout (rden, wren, address, din, acq, dq) is documented in the package header so both ends stay consistent.

Test Plan:
- Read: accept read at addr 0x3C. Controller model raises acq 1 cycle after rden and presents dq=0xA5 on the 2nd acq cycle.
  - rden high for 3 cycles, address=0x3C.
  - rsp_valid pulse 4 cycles after accept, rsp_rdata=0xA5, rsp_err=0.
- Write: accept write addr 0x10, data 0x5A.
  - wren=1, din=0x5A, rden=0 until 2 acq-high cycles have elapsed.
  - rsp_valid=1, rsp_err=0, rsp_rdata unchanged.
- Contention: acq withheld 10 cycles (other core granted), then given.
  - rden held stable all 10 cycles.
  - Completes normally. req_ready stays 0 until acq falls in RELEASE.
- Timeout: TIMEOUT=64, acq never asserted.
  - At wait cycle 64, rden drops and rsp_valid=rsp_err=1 for one cycle.
  - Port returns to IDLE.
- Early acq drop: acq high 1 cycle then low, with HOLD_CYCLES=2.
  - rsp_err pulse. rsp_rdata retains the previous value 0xA5.
- Reset mid-HOLD: pull rst_n low asynchronously.
  - rden/wren go to 0 without waiting for a clock edge. No rsp_valid.
  - After release, req_ready=1 and a new read to 0x01 completes normally.
